// File: rtl/smart_led_pkg.sv
// Shared types and default timing for the smart LED frame sequencer.
// Timing constants are in clk cycles.
package smart_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam int DEF_N_BITS  = 30;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_T_MIN   = 4;
    localparam int DEF_T_ONE   = 24;
    localparam int DEF_T_RESET = 2400;

endpackage

// File: rtl/smart_led_sync_edge.sv
// Two-flop synchronizer for the asynchronous LED input plus a registered
// edge detector.
// Ports: clk, rst_n (async, active-low), din_i (raw input),
//        din_sync_o (synchronized level), rise_o / fall_o (one-cycle
//        edge pulses, 2 clk after the raw edge, aligned with din_sync_o).
module smart_led_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic din_sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic rise_q;
    logic fall_q;

    // Edges are taken between the two sync stages so that the pulse
    // appears in the same cycle the second stage shows the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            rise_q <= s1_q & ~s2_q;
            fall_q <= ~s1_q & s2_q;
        end
    end

    assign din_sync_o = s2_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;

endmodule

// File: rtl/smart_led_frame_ctrl.sv
// Front-end sequencer for a serial-to-parallel LED register: decodes the
// pulse-width one-wire stream, shifts the first N_BITS bits locally and
// forwards the rest of the frame on dout; a long low gap ends the frame.
// Ports: clk, rst_n (async, active-low), din (raw stream),
//        sr_data/sr_clk (shift strobe with bit), sr_store (store strobe),
//        dout (forwarded stream), frame_err (partial frame at gap),
//        busy (frame in progress), bit_cnt (local bits this frame).
module smart_led_frame_ctrl
    import smart_led_pkg::*;
#(
    parameter int N_BITS  = DEF_N_BITS,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int T_MIN   = DEF_T_MIN,
    parameter int T_ONE   = DEF_T_ONE,
    parameter int T_RESET = DEF_T_RESET
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din,
    output logic                          sr_data,
    output logic                          sr_clk,
    output logic                          sr_store,
    output logic                          dout,
    output logic                          frame_err,
    output logic                          busy,
    output logic [$clog2(N_BITS+1)-1:0]   bit_cnt
);

    localparam int BW = $clog2(N_BITS + 1);

    localparam logic [CNT_W-1:0] TC_MAX = '1;
    // tcnt is cleared on the edge that enters a state, so a level lasting
    // H cycles is seen as tcnt == H-1 when its ending edge is processed.
    localparam logic [CNT_W-1:0] TC_MIN = CNT_W'(T_MIN - 1);
    localparam logic [CNT_W-1:0] TC_ONE = CNT_W'(T_ONE - 1);
    localparam logic [CNT_W-1:0] TC_RST = CNT_W'(T_RESET - 1);
    localparam logic [BW-1:0]    NB     = BW'(N_BITS);

    logic din_sync;
    logic rise_s;
    logic fall_s;

    smart_led_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_i      (din),
        .din_sync_o (din_sync),
        .rise_o     (rise_s),
        .fall_o     (fall_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             fwd_q, fwd_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             sclk_q, sclk_d;
    logic             sdat_q, sdat_d;
    logic             stor_q, stor_d;
    logic             err_q, err_d;
    logic             dout_q, dout_d;
    logic             full;

    assign full = (cnt_q == NB);

    always_comb begin
        state_d = state_q;
        tcnt_d  = (tcnt_q == TC_MAX) ? tcnt_q : tcnt_q + CNT_W'(1);
        cnt_d   = cnt_q;
        fwd_d   = fwd_q;
        gate_d  = gate_q;
        busy_d  = busy_q;
        sclk_d  = 1'b0;
        sdat_d  = 1'b0;
        stor_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                gate_d = 1'b0;
                busy_d = 1'b0;
                if (rise_s) begin
                    state_d = ST_HIGH;
                    fwd_d   = full;
                    gate_d  = full;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    if (tcnt_q < TC_MIN) begin
                        state_d = busy_q ? ST_LOW : ST_IDLE;
                    end else begin
                        state_d = ST_LOW;
                        if (!fwd_q && !full) begin
                            sclk_d = 1'b1;
                            sdat_d = (tcnt_q >= TC_ONE);
                            cnt_d  = cnt_q + BW'(1);
                            busy_d = 1'b1;
                        end
                    end
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    fwd_d   = full;
                    if (full) begin
                        gate_d = 1'b1;
                    end
                end else if (tcnt_q >= TC_RST) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (full) begin
                    stor_d = 1'b1;
                end else if (cnt_q != '0) begin
                    err_d = 1'b1;
                end
                cnt_d   = '0;
                busy_d  = 1'b0;
                fwd_d   = 1'b0;
                gate_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            tcnt_d = '0;
        end

        // Gate uses the next value so the first cycle of a forwarded
        // pulse is not lost; both edges then share the same delay.
        dout_d = din_sync & gate_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            cnt_q   <= '0;
            fwd_q   <= 1'b0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdat_q  <= 1'b0;
            stor_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            cnt_q   <= cnt_d;
            fwd_q   <= fwd_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            sdat_q  <= sdat_d;
            stor_q  <= stor_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign sr_clk    = sclk_q;
    assign sr_data   = sdat_q;
    assign sr_store  = stor_q;
    assign frame_err = err_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign bit_cnt   = cnt_q;

endmodule
